// File: rtl/md5_block_feeder_pkg.sv
// Shared constants, FSM state type and word byte-swap helper for the MD5 block feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package md5_block_feeder_pkg;

  localparam int          BLOCK_BYTES = 64;
  localparam int          BEAT_W      = 128;
  localparam int          LEN_OFFSET  = 56;
  localparam logic [7:0]  PAD_BYTE    = 8'h80;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PAD     = 2'd1,
    EMIT    = 2'd2
  } state_e;

  // Reverse the byte order inside each 32-bit word of a beat, turning the
  // first-byte-at-MSB packing into little-endian MD5 message words.
  function automatic logic [BEAT_W-1:0] swap_words(input logic [BEAT_W-1:0] x);
    logic [BEAT_W-1:0] y;
    y = '0;
    for (int w = 0; w < BEAT_W / 32; w++) begin
      for (int b = 0; b < 4; b++) begin
        y[32*w + 8*b +: 8] = x[32*w + 8*(3-b) +: 8];
      end
    end
    return y;
  endfunction

endpackage

// File: rtl/md5_block_feeder_if.sv
// Byte-stream input and 4-beat block output bundle of the MD5 block feeder.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the byte side; core_ready gates the start of a block.
// Ports: master = feeder side, slave = byte producer plus MD5 core side.
interface md5_block_feeder_if;
  import md5_block_feeder_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_empty;
  logic              core_ready;
  logic [BEAT_W-1:0] data_o;
  logic              en1;
  logic              en2;
  logic              en3;
  logic              en4;
  logic              blk_last;
  logic              busy;

  modport master (
    input  in_valid, in_data, in_last, in_empty, core_ready,
    output in_ready, data_o, en1, en2, en3, en4, blk_last, busy
  );

  modport slave (
    output in_valid, in_data, in_last, in_empty, core_ready,
    input  in_ready, data_o, en1, en2, en3, en4, blk_last, busy
  );

endinterface

// File: rtl/md5_block_feeder_block_buf.sv
// 64-byte block buffer: byte write, zero-fill from an index, length write, 128-bit beat read.
// Latency: writes land on the next posedge; beat read is combinational.
// Backpressure: none; the owner only writes while no block is being emitted.
// Ports: clk/reset (sync, active low); wr_* byte port; fill_* zero-fill of bytes >= fill_idx_i;
//        len_* stores len_i little-endian in bytes 56..63; rd_beat_i selects rd_dat_o.
module md5_block_feeder_block_buf
  import md5_block_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [5:0]        wr_idx_i,
  input  logic [7:0]        wr_dat_i,
  input  logic              fill_en_i,
  input  logic [6:0]        fill_idx_i,
  input  logic              len_en_i,
  input  logic [63:0]       len_i,
  input  logic [1:0]        rd_beat_i,
  output logic [BEAT_W-1:0] rd_dat_o
);

  logic [7:0] mem_q [BLOCK_BYTES];

  // Length beats the zero-fill in bytes 56..63; the 0x80 write beats the
  // zero-fill at its own index.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (!reset) begin
        mem_q[i] <= '0;
      end else if (len_en_i && i >= LEN_OFFSET) begin
        mem_q[i] <= len_i[8*(i%8) +: 8];
      end else if (wr_en_i && wr_idx_i == 6'(i)) begin
        mem_q[i] <= wr_dat_i;
      end else if (fill_en_i && 7'(i) >= fill_idx_i) begin
        mem_q[i] <= '0;
      end
    end
  end

  // Byte 16*beat+k sits at bits [127-8k -: 8]: first byte is the MSB.
  always_comb begin
    rd_dat_o = '0;
    for (int k = 0; k < 16; k++) begin
      rd_dat_o[BEAT_W-1-8*k -: 8] = mem_q[{rd_beat_i, 4'(k)}];
    end
  end

endmodule

// File: rtl/md5_block_feeder.sv
// MD5 block feeder: buffers a byte stream into 64-byte blocks, applies MD5 padding, emits 4x128-bit beats.
// Latency: en1 one cycle after the 64th byte / pad cycle (core_ready high), or one cycle after core_ready rises.
// Backpressure: in_ready low outside COLLECT; core_ready checked only before en1, a started block always finishes.
// Ports: clk, reset (sync, active low); bus (md5_block_feeder_if.master) carries byte input and beat output.
// Optional: MD5_BYTE_SWAP_EN byte-reverses each 32-bit word of data_o.
module md5_block_feeder
  import md5_block_feeder_pkg::*;
#(
  parameter int LEN_W    = 64,
  parameter int BEAT_GAP = 0
)
(
  input  logic                clk,
  input  logic                reset,
  md5_block_feeder_if.master  bus
);

  state_e            state_q, state_d;
  logic [6:0]        count_q, count_d;
  logic [LEN_W-1:0]  bitlen_q, bitlen_d;
  logic              pad_placed_q, pad_placed_d;
  logic              final_q, final_d;
  logic              pad_more_q, pad_more_d;   // a second pad pass follows this block
  logic              active_q, active_d;       // en1 issued, beats in flight
  logic [1:0]        beat_q, beat_d;
  logic [1:0]        gap_q, gap_d;
  logic [3:0]        en_q, en_d;
  logic              blk_last_q, blk_last_d;
  logic              busy_q, busy_d;

  logic              xfer;
  logic              has_byte;
  logic              place;
  logic              buf_wr_en;
  logic [5:0]        buf_wr_idx;
  logic [7:0]        buf_wr_dat;
  logic              buf_fill_en;
  logic [6:0]        buf_fill_idx;
  logic              buf_len_en;
  logic [63:0]       len64;
  logic [BEAT_W-1:0] buf_rd_dat;
  logic [BEAT_W-1:0] beat_dat;

  assign bus.in_ready = reset && (state_q == COLLECT) && (count_q < 7'(BLOCK_BYTES));
  assign xfer         = bus.in_valid && bus.in_ready;
  assign has_byte     = xfer && !bus.in_empty;
  assign len64        = 64'(bitlen_q);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    bitlen_d     = bitlen_q;
    pad_placed_d = pad_placed_q;
    final_d      = final_q;
    pad_more_d   = pad_more_q;
    active_d     = active_q;
    beat_d       = beat_q;
    gap_d        = gap_q;
    en_d         = 4'b0000;
    blk_last_d   = 1'b0;
    busy_d       = busy_q;
    place        = 1'b0;
    buf_wr_en    = 1'b0;
    buf_wr_idx   = count_q[5:0];
    buf_wr_dat   = bus.in_data;
    buf_fill_en  = 1'b0;
    buf_fill_idx = count_q;
    buf_len_en   = 1'b0;

    unique case (state_q)
      COLLECT: begin
        if (has_byte) begin
          buf_wr_en = 1'b1;
          count_d   = count_q + 7'd1;
          bitlen_d  = bitlen_q + LEN_W'(8);
          busy_d    = 1'b1;
        end
        if (xfer && bus.in_last) begin
          state_d = PAD;
          busy_d  = 1'b1;
        end else if (has_byte && count_q == 7'd63) begin
          state_d    = EMIT;
          final_d    = 1'b0;
          pad_more_d = 1'b0;
          if (bus.core_ready) begin
            active_d = 1'b1;
            beat_d   = 2'd0;
            en_d     = 4'b0001;
          end
        end
      end

      PAD: begin
        place        = !pad_placed_q && (count_q < 7'(BLOCK_BYTES));
        buf_wr_en    = place;
        buf_wr_dat   = PAD_BYTE;
        buf_fill_en  = 1'b1;
        buf_fill_idx = place ? count_q + 7'd1 : count_q;
        pad_placed_d = pad_placed_q | place;
        // Length fits if the 0x80 went into an earlier block or lands at byte <= 55.
        if (pad_placed_q || count_q <= 7'(LEN_OFFSET - 1)) begin
          buf_len_en = 1'b1;
          final_d    = 1'b1;
          pad_more_d = 1'b0;
        end else begin
          final_d    = 1'b0;
          pad_more_d = 1'b1;
        end
        state_d = EMIT;
        if (bus.core_ready) begin
          active_d = 1'b1;
          beat_d   = 2'd0;
          en_d     = 4'b0001;
        end
      end

      EMIT: begin
        if (!active_q) begin
          if (bus.core_ready) begin
            active_d = 1'b1;
            beat_d   = 2'd0;
            en_d     = 4'b0001;
          end
        end else if (en_q != 4'b0000 && beat_q == 2'd3) begin
          active_d = 1'b0;
          count_d  = '0;
          if (pad_more_q) begin
            state_d    = PAD;
            pad_more_d = 1'b0;
          end else begin
            state_d = COLLECT;
          end
          if (final_q) begin
            bitlen_d     = '0;
            busy_d       = 1'b0;
            pad_placed_d = 1'b0;
            final_d      = 1'b0;
          end
        end else if (en_q != 4'b0000 && BEAT_GAP != 0) begin
          gap_d = 2'(BEAT_GAP);
        end else if (en_q != 4'b0000 || gap_q == 2'd1) begin
          // Either no gap is configured or the last idle cycle is running.
          gap_d      = 2'd0;
          beat_d     = beat_q + 2'd1;
          en_d       = 4'b0001 << (beat_q + 2'd1);
          blk_last_d = final_q && (beat_q == 2'd2);
        end else begin
          gap_d = gap_q - 2'd1;
        end
      end

      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= COLLECT;
      count_q      <= '0;
      bitlen_q     <= '0;
      pad_placed_q <= 1'b0;
      final_q      <= 1'b0;
      pad_more_q   <= 1'b0;
      active_q     <= 1'b0;
      beat_q       <= '0;
      gap_q        <= '0;
      en_q         <= '0;
      blk_last_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      bitlen_q     <= bitlen_d;
      pad_placed_q <= pad_placed_d;
      final_q      <= final_d;
      pad_more_q   <= pad_more_d;
      active_q     <= active_d;
      beat_q       <= beat_d;
      gap_q        <= gap_d;
      en_q         <= en_d;
      blk_last_q   <= blk_last_d;
      busy_q       <= busy_d;
    end
  end

  md5_block_feeder_block_buf u_buf (
    .clk        (clk),
    .reset      (reset),
    .wr_en_i    (buf_wr_en),
    .wr_idx_i   (buf_wr_idx),
    .wr_dat_i   (buf_wr_dat),
    .fill_en_i  (buf_fill_en),
    .fill_idx_i (buf_fill_idx),
    .len_en_i   (buf_len_en),
    .len_i      (len64),
    .rd_beat_i  (beat_q),
    .rd_dat_o   (buf_rd_dat)
  );

`ifdef MD5_BYTE_SWAP_EN
  assign beat_dat = swap_words(buf_rd_dat);
`else
  assign beat_dat = buf_rd_dat;
`endif

  assign bus.data_o   = (en_q != 4'b0000) ? beat_dat : '0;
  assign bus.en1      = en_q[0];
  assign bus.en2      = en_q[1];
  assign bus.en3      = en_q[2];
  assign bus.en4      = en_q[3];
  assign bus.blk_last = blk_last_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_md5_block_feeder.sv
// Scoreboard bench for md5_block_feeder: directed MD5 padding cases plus randomized messages.
// Latency: checks beat spacing and en1 timing against core_ready.
// Backpressure: random in_valid gaps and random core_ready; honours MD5_BYTE_SWAP_EN.
module tb_md5_block_feeder;
  import md5_block_feeder_pkg::*;

  localparam int GAP = 0;

`ifdef MD5_BYTE_SWAP_EN
  localparam logic [127:0] ABC_EN1 = 128'h80636261_00000000_00000000_00000000;
  localparam logic [127:0] ABC_EN4 = 128'h00000000_00000000_00000018_00000000;
`else
  localparam logic [127:0] ABC_EN1 = 128'h61626380_00000000_00000000_00000000;
  localparam logic [127:0] ABC_EN4 = 128'h00000000_00000000_18000000_00000000;
`endif

  typedef struct packed {
    logic [511:0] d;
    logic         last;
  } blk_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  md5_block_feeder_if bus();

  md5_block_feeder #(.LEN_W(64), .BEAT_GAP(GAP)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  blk_t         exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  logic [127:0] rx_beat [4];
  logic [511:0] rx_blk;
  int           rx_cnt = 0;
  bit           cr_auto = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic fail_timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting, required DUT progress", nm);
  endtask

  function automatic logic [3:0] en_now();
    return {bus.en4, bus.en3, bus.en2, bus.en1};
  endfunction

  // Reference: standard MD5 padding of the whole message, then split into blocks.
  task automatic push_expected(input logic [7:0] m[$]);
    logic [7:0]   p[$];
    logic [63:0]  bl;
    logic [511:0] d;
    blk_t         e;
    int           nb;
    p  = m;
    bl = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 0; i < 8; i++) p.push_back(bl[8*i +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      d = '0;
      for (int j = 0; j < 64; j++) begin
`ifdef MD5_BYTE_SWAP_EN
        d[511 - 8*((j/4)*4 + 3 - (j%4)) -: 8] = p[64*b + j];
`else
        d[511 - 8*j -: 8] = p[64*b + j];
`endif
      end
      e.d    = d;
      e.last = (b == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  // Presents one beat; returns once in_ready is seen, the transfer is the next posedge.
  task automatic send_beat(input logic [7:0] dat, input logic last, input logic empty);
    int t;
    t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = dat;
    bus.in_last  = last;
    bus.in_empty = empty;
    while (!bus.in_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) fail_timeout("in_ready");
  endtask

  task automatic send_msg(input logic [7:0] m[$], input bit last_on_byte, input bit junk);
    push_expected(m);
    for (int i = 0; i < m.size(); i++) begin
      if (junk && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      if (junk && $urandom_range(0, 7) == 0) send_beat(8'($urandom_range(0, 255)), 1'b0, 1'b1);
      send_beat(m[i], last_on_byte && (i == m.size() - 1), 1'b0);
    end
    if (!last_on_byte || m.size() == 0) send_beat(8'h00, 1'b1, 1'b1);
    idle(1);
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) fail_timeout(nm);
    repeat (2) @(negedge clk);
  endtask

  task automatic idle_check(input string nm);
    chk({nm, "_busy"}, 128'(bus.busy), 128'(1'b0));
    chk({nm, "_in_ready"}, 128'(bus.in_ready), 128'(1'b1));
  endtask

  // Monitor: assembles beats, checks strobe order/spacing and compares against the scoreboard.
  initial begin
    int          bi;
    int          last_cyc;
    logic [3:0]  en;
    blk_t        e;
    bi = 0;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bi = 0;
      end else begin
        en = en_now();
        if (en != 4'b0000) begin
          chk("en_onehot_index", 128'(en), 128'(4'b0001 << bi));
          if (bi > 0) chk("beat_spacing", 128'(cyc - last_cyc), 128'(GAP + 1));
          last_cyc = cyc;
          rx_beat[bi] = bus.data_o;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: en %b with empty scoreboard, required no beat", en);
          end else begin
            e = exp_q[0];
            chk("data_o_beat", bus.data_o, e.d[511 - 128*bi -: 128]);
            chk("blk_last", 128'(bus.blk_last), 128'((bi == 3) && e.last));
          end
          if (bi == 3) begin
            rx_blk = {rx_beat[0], rx_beat[1], rx_beat[2], rx_beat[3]};
            rx_cnt++;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            bi = 0;
          end else begin
            bi++;
          end
        end else begin
          chk("blk_last_idle", 128'(bus.blk_last), 128'(1'b0));
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cr_auto) bus.core_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic [7:0]   msg[$];
    logic [511:0] abc_ref;
    int           c0;
    int           t;

    bus.in_valid   = 1'b0;
    bus.in_data    = 8'h00;
    bus.in_last    = 1'b0;
    bus.in_empty   = 1'b0;
    bus.core_ready = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1'b0));
    chk("rst_en", 128'(en_now()), 128'(4'b0000));
    chk("rst_data_o", bus.data_o, 128'h0);
    chk("rst_busy", 128'(bus.busy), 128'(1'b0));
    chk("rst_blk_last", 128'(bus.blk_last), 128'(1'b0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 128'(bus.in_ready), 128'(1'b1));
    bus.core_ready = 1'b1;

    // "abc"
    msg = '{8'h61, 8'h62, 8'h63};
    send_msg(msg, 1'b1, 1'b0);
    drain("abc");
    chk("abc_en1", rx_blk[511:384], ABC_EN1);
    chk("abc_en2", rx_blk[383:256], 128'h0);
    chk("abc_en4", rx_blk[127:0], ABC_EN4);
    abc_ref = rx_blk;
    idle_check("abc_idle");

    // 55 bytes: 0x80 and length share one block
    msg.delete();
    for (int i = 0; i < 55; i++) msg.push_back(8'h41);
    c0 = rx_cnt;
    send_msg(msg, 1'b1, 1'b0);
    drain("len55");
    chk("len55_blocks", 128'(rx_cnt - c0), 128'(1));

    // 56 bytes: length spills into a second block
    msg.push_back(8'h41);
    c0 = rx_cnt;
    send_msg(msg, 1'b1, 1'b0);
    drain("len56");
    chk("len56_blocks", 128'(rx_cnt - c0), 128'(2));

    // 64 bytes then last&empty
    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'(i));
    c0 = rx_cnt;
    send_msg(msg, 1'b0, 1'b0);
    drain("len64_empty");
    chk("len64_blocks", 128'(rx_cnt - c0), 128'(2));

    // empty message
    msg.delete();
    c0 = rx_cnt;
    send_msg(msg, 1'b0, 1'b0);
    drain("empty_msg");
    chk("empty_blocks", 128'(rx_cnt - c0), 128'(1));
    idle_check("empty_idle");

    // core_ready held low; a valid byte held meanwhile must not be taken
    bus.core_ready = 1'b0;
    msg = '{8'h61, 8'h62, 8'h63};
    send_msg(msg, 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    bus.in_last  = 1'b0;
    bus.in_empty = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_en", 128'(en_now()), 128'(4'b0000));
      chk("stall_in_ready", 128'(bus.in_ready), 128'(1'b0));
    end
    bus.in_valid   = 1'b0;
    bus.core_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_en1", 128'(en_now()), 128'(4'b0001));
    bus.core_ready = 1'b0;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("no_stall_mid_block", 128'(en_now()), 128'(4'b0001 << k));
    end
    bus.core_ready = 1'b1;
    drain("stall");
    chk("stall_block_en1", rx_blk[511:384], ABC_EN1);

    // reset between en2 and en3
    msg = '{8'h61, 8'h62, 8'h63};
    send_msg(msg, 1'b1, 1'b0);
    t = 0;
    while (!bus.en2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) fail_timeout("wait_en2");
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_en", 128'(en_now()), 128'(4'b0000));
    chk("midrst_data_o", bus.data_o, 128'h0);
    chk("midrst_in_ready", 128'(bus.in_ready), 128'(1'b0));
    chk("midrst_busy", 128'(bus.busy), 128'(1'b0));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("after_rst_en", 128'(en_now()), 128'(4'b0000));
    end
    send_msg(msg, 1'b1, 1'b0);
    drain("abc_after_rst");
    chk("abc_repeat_block_hi", rx_blk[511:256], abc_ref[511:256]);
    chk("abc_repeat_block_lo", rx_blk[255:0], abc_ref[255:0]);

    // randomized messages with random core_ready and input gaps
    cr_auto = 1'b1;
    for (int m = 0; m < 25; m++) begin
      int L;
      case ($urandom_range(0, 3))
        0:       L = int'($urandom_range(0, 3));
        1:       L = int'($urandom_range(52, 68));
        2:       L = int'($urandom_range(115, 130));
        default: L = int'($urandom_range(0, 200));
      endcase
      msg.delete();
      for (int i = 0; i < L; i++) msg.push_back(8'($urandom_range(0, 255)));
      send_msg(msg, ($urandom_range(0, 1) == 1), 1'b1);
    end
    drain("random");
    cr_auto = 1'b0;
    bus.core_ready = 1'b1;
    chk("random_scoreboard_empty", 128'(exp_q.size()), 128'(0));
    idle_check("random_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
